// File: rtl/sram_nr1w_be.sv
// Block SRAM with NUM_READ_PORTS synchronous read ports and one byte-masked write port.
// Includes read-during-write merge bypass, an optional second read stage and a clear sweeper.
module sram_nr1w_be #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    SIZE              = 1024,
    parameter int                    NUM_READ_PORTS    = 2,
    parameter int                    READ_LATENCY      = 1,
    parameter string                 READ_DURING_WRITE = "NEW_DATA",
    parameter bit                    CLEAR_ON_RESET    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE       = '0,
    parameter int                    ADDR_WIDTH        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_READ_PORTS-1:0]            read_en,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    input  logic                                 write_en,
    input  logic [DATA_WIDTH/8-1:0]              write_byte_en,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 clear_req,
    output logic                                 init_done,
    output logic                                 o_dbg_clearing
);

    localparam int                    NUM_BYTES  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   SIZE_W     = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(SIZE - 1);
    localparam bit                    BYPASS_NEW = (READ_DURING_WRITE == "NEW_DATA");

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                               r_state;
    logic [ADDR_WIDTH-1:0]                r_cnt;
    logic                                 r_init_done;
    logic [DATA_WIDTH-1:0]                r_mem [SIZE];
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] r_rd1;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] w_rd_next;
    logic [DATA_WIDTH-1:0]                w_wr_mask;
    logic [DATA_WIDTH-1:0]                w_wr_word;
    logic                                 w_wr_commit;

    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_wr_mask[8*b +: 8] = {8{write_byte_en[b]}};
        end
    end

    // User writes only land in READY and only for in-range addresses.
    assign w_wr_commit = (r_state == ST_READY) && write_en && (write_byte_en != '0)
                         && ({1'b0, write_addr} < SIZE_W);
    assign w_wr_word   = (r_mem[write_addr] & ~w_wr_mask) | (write_data & w_wr_mask);

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_wr_commit) begin
            r_mem[write_addr] <= w_wr_word;
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_addr;
            logic [DATA_WIDTH-1:0] w_old;
            logic                  w_hit;
            assign w_addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_old  = r_mem[w_addr];
            assign w_hit  = BYPASS_NEW && w_wr_commit && (write_addr == w_addr);
            assign w_rd_next[p*DATA_WIDTH +: DATA_WIDTH] =
                (r_state == ST_CLEAR) ? CLEAR_VALUE :
                w_hit                 ? w_wr_word   : w_old;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd1 <= '0;
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (read_en[p]) begin
                    r_rd1[p*DATA_WIDTH +: DATA_WIDTH] <= w_rd_next[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_READ_PORTS-1:0]            r_v1;
            logic [NUM_READ_PORTS*DATA_WIDTH-1:0] r_rd2;
            // Stage 2 copies only freshly sampled stage-1 data, so idle ports hold.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_v1  <= '0;
                    r_rd2 <= '0;
                end else begin
                    r_v1 <= read_en;
                    for (int p = 0; p < NUM_READ_PORTS; p++) begin
                        if (r_v1[p]) begin
                            r_rd2[p*DATA_WIDTH +: DATA_WIDTH] <= r_rd1[p*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            assign read_data = r_rd2;
        end else begin : g_lat1
            assign read_data = r_rd1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_cnt       <= '0;
            r_init_done <= !CLEAR_ON_RESET;
        end else begin
            case (r_state)
                ST_READY: begin
                    if (clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_cnt       <= '0;
                        r_init_done <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt       <= '0;
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign init_done      = r_init_done;
    assign o_dbg_clearing = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_sram_nr1w_be.sv
// Bench for sram_nr1w_be: two instances (16 entries/latency 1/new-data and
// 12 entries/latency 2/old-data) share stimulus and are checked against an array model.
module tb_sram_nr1w_be;

    localparam logic [31:0] CV_A = 32'hC1EA_C1EA;
    localparam logic [31:0] CV_B = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  read_en;
    logic [7:0]  read_addr;
    logic        write_en;
    logic [3:0]  write_byte_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        clear_req;
    logic [63:0] rd_a, rd_b;
    logic        init_a, init_b, dbg_a, dbg_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
        bit          def;
    } exp_t;

    exp_t        exp_q_a[$];
    exp_t        exp_q_b[$];
    exp_t        mon_e;
    logic [31:0] m_mem   [2][16];
    int          m_rem   [2];
    bit          exp_init[2];
    logic [31:0] cur_exp [2][2];
    bit          cur_def [2][2];

    sram_nr1w_be #(
        .DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(2), .READ_LATENCY(1),
        .READ_DURING_WRITE("NEW_DATA"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV_A)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(rd_a), .write_en(write_en), .write_byte_en(write_byte_en),
        .write_addr(write_addr), .write_data(write_data), .clear_req(clear_req),
        .init_done(init_a), .o_dbg_clearing(dbg_a)
    );

    sram_nr1w_be #(
        .DATA_WIDTH(32), .SIZE(12), .NUM_READ_PORTS(2), .READ_LATENCY(2),
        .READ_DURING_WRITE("OLD_DATA"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV_B)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(rd_b), .write_en(write_en), .write_byte_en(write_byte_en),
        .write_addr(write_addr), .write_data(write_data), .clear_req(clear_req),
        .init_done(init_b), .o_dbg_clearing(dbg_b)
    );

    // Clock / reset
    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int sz(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] cv(input int i);
        return (i == 0) ? CV_A : CV_B;
    endfunction

    function automatic bit new_data(input int i);
        return (i == 0);
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (write_byte_en[b]) r[8*b +: 8] = write_data[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int i, input int p, input logic [31:0] d, input bit def);
        exp_t e;
        e.due  = cyc + lat(i) - 1;
        e.port = p;
        e.data = d;
        e.def  = def;
        if (i == 0) exp_q_a.push_back(e);
        else        exp_q_b.push_back(e);
    endtask

    // Reference model: one call per rising edge, using the inputs presented at that edge.
    task automatic model_step();
        int a;
        for (int i = 0; i < 2; i++) begin
            if (m_rem[i] > 0) begin
                for (int p = 0; p < 2; p++) if (read_en[p]) push_exp(i, p, cv(i), 1'b1);
                m_mem[i][sz(i) - m_rem[i]] = cv(i);
                m_rem[i]--;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (read_en[p]) begin
                        a = int'(read_addr[p*4 +: 4]);
                        if (a >= sz(i))
                            push_exp(i, p, '0, 1'b0);
                        else if (write_en && int'(write_addr) == a && new_data(i))
                            push_exp(i, p, merged(m_mem[i][a]), 1'b1);
                        else
                            push_exp(i, p, m_mem[i][a], 1'b1);
                    end
                end
                if (write_en && int'(write_addr) < sz(i))
                    m_mem[i][write_addr] = merged(m_mem[i][write_addr]);
                if (clear_req) m_rem[i] = sz(i);
            end
            exp_init[i] = (m_rem[i] == 0);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        read_en       = '0;
        read_addr     = '0;
        write_en      = 1'b0;
        write_byte_en = '0;
        write_addr    = '0;
        write_data    = '0;
        clear_req     = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        reset_n = 1'b0;
        exp_q_a.delete();
        exp_q_b.delete();
        for (int i = 0; i < 2; i++) begin
            m_rem[i]    = sz(i);
            exp_init[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                cur_exp[i][p] = '0;
                cur_def[i][p] = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic measure_sweep(input int pulse_at, output int na, output int nb);
        na = -1;
        nb = -1;
        for (int k = 1; k <= 40 && (na < 0 || nb < 0); k++) begin
            read_en       = 2'($urandom_range(0, 3));
            read_addr     = 8'($urandom);
            write_en      = (nb < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            write_byte_en = 4'($urandom);
            write_addr    = 4'($urandom);
            write_data    = $urandom;
            clear_req     = (k == pulse_at);
            cycle();
            if (na < 0 && init_a) na = k;
            if (nb < 0 && init_b) nb = k;
        end
        set_idle();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q_a.size() > 0 && exp_q_a[0].due <= cyc) begin
                mon_e = exp_q_a.pop_front();
                cur_exp[0][mon_e.port] = mon_e.data;
                cur_def[0][mon_e.port] = mon_e.def;
            end
            while (exp_q_b.size() > 0 && exp_q_b[0].due <= cyc) begin
                mon_e = exp_q_b.pop_front();
                cur_exp[1][mon_e.port] = mon_e.data;
                cur_def[1][mon_e.port] = mon_e.def;
            end
            for (int p = 0; p < 2; p++) begin
                if (cur_def[0][p]) check($sformatf("a_rd%0d", p), rd_a[p*32 +: 32], cur_exp[0][p]);
                if (cur_def[1][p]) check($sformatf("b_rd%0d", p), rd_b[p*32 +: 32], cur_exp[1][p]);
            end
            check("a_init", {31'b0, init_a}, {31'b0, exp_init[0]});
            check("b_init", {31'b0, init_b}, {31'b0, exp_init[1]});
            check("a_dbg",  {31'b0, dbg_a},  {31'b0, !exp_init[0]});
            check("b_dbg",  {31'b0, dbg_b},  {31'b0, !exp_init[1]});
        end
    end

    // Stimulus
    initial begin
        int na, nb;
        set_idle();
        mon_en = 1'b1;

        // Power-on sweep length and contents
        apply_reset();
        measure_sweep(0, na, nb);
        check("sweep_len_a", 32'(na), 32'd16);
        check("sweep_len_b", 32'(nb), 32'd12);
        for (int i = 0; i < 16; i++) begin
            read_en   = 2'b11;
            read_addr = {4'(15 - i), 4'(i)};
            cycle();
        end
        set_idle();
        cycle();
        cycle();

        // Byte-masked write merge
        write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'd5; write_data = 32'h1122_3344;
        cycle();
        write_byte_en = 4'b0101; write_data = 32'hAABB_CCDD;
        cycle();
        set_idle();
        read_en = 2'b01; read_addr = 8'h05;
        cycle();
        check("t2_merge_a", rd_a[31:0], 32'h11BB_33DD);
        set_idle();
        cycle();
        check("t2_merge_b", rd_b[31:0], 32'h11BB_33DD);

        // Same-address read during write on both ports
        write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'd7; write_data = 32'h0;
        cycle();
        write_byte_en = 4'b1100; write_data = 32'hDEAD_BEEF;
        read_en = 2'b11; read_addr = 8'h77;
        cycle();
        check("t3_new_p0", rd_a[31:0],  32'hDEAD_0000);
        check("t3_new_p1", rd_a[63:32], 32'hDEAD_0000);
        set_idle();
        cycle();
        check("t3_old_p0", rd_b[31:0],  32'h0000_0000);
        check("t3_old_p1", rd_b[63:32], 32'h0000_0000);

        // Latency-2 timing, hold, and write after sampling
        write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'd3; write_data = 32'h5A5A_5A5A;
        cycle();
        set_idle();
        read_en = 2'b01; read_addr = 8'h03;
        cycle();
        check("t4_b_edge_n", rd_b[31:0], 32'h0000_0000);
        set_idle();
        write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'd3; write_data = 32'hFFFF_FFFF;
        cycle();
        check("t4_b_edge_n1", rd_b[31:0], 32'h5A5A_5A5A);
        set_idle();
        cycle();
        cycle();
        check("t4_b_hold", rd_b[31:0], 32'h5A5A_5A5A);

        // clear_req with concurrent write, plus an ignored mid-sweep request
        write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'd2; write_data = 32'h1;
        clear_req = 1'b1; read_en = 2'b01; read_addr = 8'h02;
        cycle();
        check("t5_bypass_a", rd_a[31:0], 32'h0000_0001);
        set_idle();
        measure_sweep(5, na, nb);
        check("t5_sweep_a", 32'(na), 32'd16);
        check("t5_sweep_b", 32'(nb), 32'd12);
        read_en = 2'b01; read_addr = 8'h02;
        cycle();
        set_idle();
        cycle();
        check("t5_cleared_a", rd_a[31:0], CV_A);
        check("t5_cleared_b", rd_b[31:0], CV_B);

        // Reset mid-sweep restarts the whole sweep
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1; write_byte_en = 4'hF; write_addr = 4'(i);
            write_data = 32'h1000_0000 | i;
            cycle();
        end
        apply_reset();
        for (int i = 0; i < 6; i++) cycle();
        apply_reset();
        measure_sweep(0, na, nb);
        check("t6_sweep_a", 32'(na), 32'd16);
        check("t6_sweep_b", 32'(nb), 32'd12);
        read_en = 2'b11; read_addr = 8'hB0;
        cycle();
        set_idle();
        cycle();
        check("t6_last_b", rd_b[63:32], CV_B);
        check("t6_first_a", rd_a[31:0], CV_A);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            read_en       = 2'($urandom_range(0, 3));
            read_addr     = 8'($urandom);
            write_en      = 1'($urandom_range(0, 1));
            write_byte_en = 4'($urandom);
            write_addr    = 4'($urandom);
            if ($urandom_range(0, 2) == 0) write_addr = read_addr[3:0];
            write_data    = $urandom;
            clear_req     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        set_idle();
        for (int k = 0; k < 3; k++) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
